alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 19 +
 rtl/alu_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/alu_seq_pkg.sv
// Purpose: shared opcode constants and FSM state encoding for alu_sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_seq_pkg;

   // Function select codes, shared by ReqOp and the ALU select lines
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_XOR = 2'b11;

   // Sequencer states: wait for a request, let the ALU settle, hold the result
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Purpose: issues one operation at a time to an external 4-bit ALU and registers its result.
// Latency: accept at edge N gives rsp_valid_o=1 after edge N+1.
// Backpressure: req_ready_o only in IDLE; the result is held until rsp_ack_i.
// Optional ALU_SEQ_ACC_EN adds req_acc_i: an accept with req_acc_i=1 takes operand A from rsp_r.
module alu_sequencer #(
   parameter int OPCNT_W = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [1:0]         req_op_i,
   input  logic [3:0]         req_a_i,
   input  logic [3:0]         req_b_i,
`ifdef ALU_SEQ_ACC_EN
   input  logic               req_acc_i,
`endif
   output logic [3:0]         alu_a_o,
   output logic [3:0]         alu_b_o,
   output logic [1:0]         alu_s_o,
   input  logic [3:0]         alu_r_i,
   input  logic               alu_cout_i,
   input  logic               alu_ovr_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ack_i,
   output logic [3:0]         rsp_r_o,
   output logic               rsp_cout_o,
   output logic               rsp_ovr_o,
   output logic               rsp_z_o,
   output logic [OPCNT_W-1:0] op_count_o
);
   import alu_seq_pkg::*;

   seq_state_t         state_q, state_d;
   logic [3:0]         alu_a_q, alu_a_d;
   logic [3:0]         alu_b_q, alu_b_d;
   logic [1:0]         alu_s_q, alu_s_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [3:0]         rsp_r_q, rsp_r_d;
   logic               rsp_cout_q, rsp_cout_d;
   logic               rsp_ovr_q, rsp_ovr_d;
   logic               rsp_z_q, rsp_z_d;
   logic [OPCNT_W-1:0] op_count_q, op_count_d;

   // Next-state and register updates; every register holds unless its state acts on it
   always_comb begin
      state_d     = state_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_s_d     = alu_s_q;
      rsp_valid_d = rsp_valid_q;
      rsp_r_d     = rsp_r_q;
      rsp_cout_d  = rsp_cout_q;
      rsp_ovr_d   = rsp_ovr_q;
      rsp_z_d     = rsp_z_q;
      op_count_d  = op_count_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
`ifdef ALU_SEQ_ACC_EN
               alu_a_d = req_acc_i ? rsp_r_q : req_a_i;
`else
               alu_a_d = req_a_i;
`endif
               alu_b_d = req_b_i;
               alu_s_d = req_op_i;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            // ALU operands have been stable for a full cycle: take its outputs
            rsp_r_d     = alu_r_i;
            rsp_cout_d  = alu_cout_i;
            rsp_ovr_d   = alu_ovr_i;
            rsp_z_d     = (alu_r_i == 4'd0);
            rsp_valid_d = 1'b1;
            op_count_d  = op_count_q + OPCNT_W'(1);
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            if (rsp_ack_i) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and data registers; reset wins over any in-flight capture or request
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         alu_a_q     <= 4'd0;
         alu_b_q     <= 4'd0;
         alu_s_q     <= 2'd0;
         rsp_valid_q <= 1'b0;
         rsp_r_q     <= 4'd0;
         rsp_cout_q  <= 1'b0;
         rsp_ovr_q   <= 1'b0;
         rsp_z_q     <= 1'b1;
         op_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_s_q     <= alu_s_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_r_q     <= rsp_r_d;
         rsp_cout_q  <= rsp_cout_d;
         rsp_ovr_q   <= rsp_ovr_d;
         rsp_z_q     <= rsp_z_d;
         op_count_q  <= op_count_d;
      end
   end

   assign req_ready_o = (state_q == ST_IDLE);
   assign alu_a_o     = alu_a_q;
   assign alu_b_o     = alu_b_q;
   assign alu_s_o     = alu_s_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_r_o     = rsp_r_q;
   assign rsp_cout_o  = rsp_cout_q;
   assign rsp_ovr_o   = rsp_ovr_q;
   assign rsp_z_o     = rsp_z_q;
   assign op_count_o  = op_count_q;

endmodule
